// File: rtl/euclid_fold_ctrl.sv
// Folded euclidean-solver controller: loads one P-beat problem, recirculates it
// NPASS times through an external CHAIN_LAT-deep cell chain plus a LOOP_DLY
// delay line, then presents the final pass on the out_* port.
module euclid_fold_ctrl #(
  parameter int W          = 13,
  parameter int DW         = 5,
  parameter int CHAIN_LAT  = 4,
  parameter int LOOP_DLY   = 8,
  parameter int NPASS      = 4,
  parameter int STOP_EXTRA = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_deg_r,
  input  logic [DW-1:0] in_deg_q,
  input  logic          in_stop,
  input  logic          in_start,
  input  logic [W-1:0]  in_r,
  input  logic [W-1:0]  in_q,
  input  logic [W-1:0]  in_l,
  input  logic [W-1:0]  in_u,
  output logic [DW-1:0] ch_deg_r,
  output logic [DW-1:0] ch_deg_q,
  output logic          ch_stop,
  output logic          ch_start,
  output logic [W-1:0]  ch_r,
  output logic [W-1:0]  ch_q,
  output logic [W-1:0]  ch_l,
  output logic [W-1:0]  ch_u,
  input  logic [DW-1:0] cr_deg_r,
  input  logic [DW-1:0] cr_deg_q,
  input  logic          cr_stop,
  input  logic          cr_start,
  input  logic [W-1:0]  cr_r,
  input  logic [W-1:0]  cr_q,
  input  logic [W-1:0]  cr_l,
  input  logic [W-1:0]  cr_u,
  output logic          out_valid,
  output logic [W-1:0]  out_l,
  output logic [W-1:0]  out_u,
  output logic [DW-1:0] out_deg_r,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int P   = CHAIN_LAT + LOOP_DLY;
  localparam int CW  = (P > 1) ? $clog2(P) : 1;
  localparam int PW  = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int SDL = LOOP_DLY + STOP_EXTRA;
  // Record of everything except stop: {deg_r, deg_q, start, r, q, l, u}.
  localparam int RW  = 2*DW + 1 + 4*W;
  localparam logic [RW-1:0] REC_RST = {{(RW-1){1'b0}}, 1'b1} << (4*W);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cyc;
  logic [PW-1:0]   pass;
  logic            sel;
  logic [RW-1:0]   in_rec;
  logic            in_stp;
  logic [RW-1:0]   rec_dly [LOOP_DLY];
  logic            stp_dly [SDL];
  logic [RW-1:0]   cr_rec;
  logic [RW-1:0]   ch_rec;
  logic            accept, gap, flush, cyc_last, out_last;

  assign accept   = in_valid && (state == IDLE || state == LOAD) && !abort;
  assign gap      = (state == LOAD) && !in_valid && !abort;
  assign flush    = abort || gap;
  assign cyc_last = (cyc == CW'(P-1));
  assign out_last = (state == OUT) && (cyc == CW'(CHAIN_LAT));
  assign cr_rec   = {cr_deg_r, cr_deg_q, cr_start, cr_r, cr_q, cr_l, cr_u};
  assign {ch_deg_r, ch_deg_q, ch_start, ch_r, ch_q, ch_l, ch_u} = ch_rec;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: begin
        if (!in_valid)     state_next = IDLE;
        else if (cyc_last) state_next = RUN;
      end
      RUN:  if (pass == PW'(NPASS-1) && cyc == CW'(CHAIN_LAT)) state_next = OUT;
      OUT:  if (out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Outputs and chain-input mux
  always_comb begin
    in_ready  = (state == IDLE || state == LOAD) && !abort;
    busy      = (state != IDLE);
    out_valid = (state == OUT);
    done      = out_last;
    out_l     = '0;
    out_u     = '0;
    out_deg_r = '0;
    if (state == OUT) begin
      out_l     = cr_l;
      out_u     = cr_u;
      out_deg_r = cr_deg_r;
    end
    ch_rec  = sel ? rec_dly[LOOP_DLY-1] : in_rec;
    ch_stop = sel ? stp_dly[SDL-1]      : in_stp;
  end

  // Beat and pass counters; they free-run whenever the FSM is not idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc  <= '0;
      pass <= '0;
    end else if (state_next == IDLE) begin
      cyc  <= '0;
      pass <= '0;
    end else begin
      cyc <= cyc_last ? '0 : cyc + 1'b1;
      if (cyc_last) pass <= (pass == PW'(NPASS-1)) ? '0 : pass + 1'b1;
    end
  end

  // Sticky load-gap flag, cleared by the next accepted problem
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       err <= 1'b0;
    else if (gap)                     err <= 1'b1;
    else if (state == IDLE && accept) err <= 1'b0;
  end

  // Input register, recirculation select and loop delay lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel    <= 1'b0;
      in_rec <= REC_RST;
      in_stp <= 1'b1;
      for (int unsigned i = 0; i < LOOP_DLY; i++) rec_dly[i] <= REC_RST;
      for (int unsigned i = 0; i < SDL; i++)      stp_dly[i] <= 1'b1;
    end else if (flush) begin
      sel    <= 1'b0;
      in_rec <= REC_RST;
      in_stp <= 1'b1;
      for (int unsigned i = 0; i < LOOP_DLY; i++) rec_dly[i] <= REC_RST;
      for (int unsigned i = 0; i < SDL; i++)      stp_dly[i] <= 1'b1;
    end else begin
      // Select goes high one cycle after RUN is entered, i.e. P cycles after
      // the first pass-0 beat reaches the chain, and drops with the done beat.
      sel    <= (state == RUN) || ((state == OUT) && !out_last);
      in_rec <= accept ? {in_deg_r, in_deg_q, in_start, in_r, in_q, in_l, in_u} : REC_RST;
      in_stp <= accept ? in_stop : 1'b1;
      rec_dly[0] <= cr_rec;
      for (int unsigned i = 1; i < LOOP_DLY; i++) rec_dly[i] <= rec_dly[i-1];
      stp_dly[0] <= cr_stop;
      for (int unsigned i = 1; i < SDL; i++)      stp_dly[i] <= stp_dly[i-1];
    end
  end

endmodule

// File: tb/tb_euclid_fold_ctrl.sv
// Bench for euclid_fold_ctrl: cycle-indexed reference model of the problem
// timeline, driven by directed and randomized problems with an identity or
// random cell chain.
module tb_euclid_fold_ctrl;
  localparam int W = 13, DW = 5, CL = 4, LD = 8, NP = 4, SE = 3;
  localparam int P = CL + LD;
  localparam int END = NP*P + CL;   // last busy cycle relative to acceptance
  localparam int RW = 2*DW + 2 + 4*W;
  localparam int STOPB = 4*W + 1;
  localparam int HN = 4096;

  logic clk = 1'b0, reset = 1'b0, abort = 1'b0, in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_deg_r = '0, in_deg_q = '0, ch_deg_r, ch_deg_q, cr_deg_r, cr_deg_q, out_deg_r;
  logic in_stop = 1'b1, in_start = 1'b1, ch_stop, ch_start, cr_stop, cr_start;
  logic [W-1:0] in_r = '0, in_q = '0, in_l = '0, in_u = '0;
  logic [W-1:0] ch_r, ch_q, ch_l, ch_u, cr_r, cr_q, cr_l, cr_u, out_l, out_u;
  logic out_valid, done, busy, err;

  euclid_fold_ctrl #(.W(W), .DW(DW), .CHAIN_LAT(CL), .LOOP_DLY(LD), .NPASS(NP), .STOP_EXTRA(SE)) dut (
    .clk(clk), .reset(reset), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_deg_r(in_deg_r), .in_deg_q(in_deg_q), .in_stop(in_stop), .in_start(in_start),
    .in_r(in_r), .in_q(in_q), .in_l(in_l), .in_u(in_u),
    .ch_deg_r(ch_deg_r), .ch_deg_q(ch_deg_q), .ch_stop(ch_stop), .ch_start(ch_start),
    .ch_r(ch_r), .ch_q(ch_q), .ch_l(ch_l), .ch_u(ch_u),
    .cr_deg_r(cr_deg_r), .cr_deg_q(cr_deg_q), .cr_stop(cr_stop), .cr_start(cr_start),
    .cr_r(cr_r), .cr_q(cr_q), .cr_l(cr_l), .cr_u(cr_u),
    .out_valid(out_valid), .out_l(out_l), .out_u(out_u), .out_deg_r(out_deg_r),
    .done(done), .busy(busy), .err(err));

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int checks = 0, errors = 0;
  logic [RW-1:0] rst_rec;
  logic [RW-1:0] chist [HN];
  logic [RW-1:0] crhist [HN];
  logic [RW-1:0] beats [P];
  bit m_active = 1'b0, m_err = 1'b0;
  int m_t0 = 0, m_flush = 0;
  bit ident = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cnt, act, exp);
    end
  endtask

  // Chain input in cycle n: the chain return from LD cycles earlier for data,
  // LD+SE for stop, unless a flush came in between.
  function automatic logic [RW-1:0] recirc(input int n);
    logic [RW-1:0] r;
    logic [RW-1:0] s;
    r = (n - LD > m_flush) ? crhist[(n-LD) % HN] : rst_rec;
    s = (n - LD - SE > m_flush) ? crhist[(n-LD-SE) % HN] : rst_rec;
    r[STOPB] = s[STOPB];
    return r;
  endfunction

  // Reference model and per-cycle comparison
  always @(negedge clk) begin
    logic [RW-1:0] ch_now, in_now, exp_ch;
    int k;
    bit exp_rdy, exp_ov;
    ch_now = {ch_deg_r, ch_deg_q, ch_stop, ch_start, ch_r, ch_q, ch_l, ch_u};
    in_now = {in_deg_r, in_deg_q, in_stop, in_start, in_r, in_q, in_l, in_u};
    chist[cnt % HN]  = ch_now;
    crhist[cnt % HN] = {cr_deg_r, cr_deg_q, cr_stop, cr_start, cr_r, cr_q, cr_l, cr_u};
    if (!reset) begin
      m_active = 1'b0;
      m_err    = 1'b0;
      m_flush  = cnt;
    end
    k = cnt - m_t0;
    exp_rdy = (!m_active || k <= P-1) && !abort;
    if (!m_active)   exp_ch = rst_rec;
    else if (k <= P) exp_ch = beats[k-1];
    else             exp_ch = recirc(cnt);
    exp_ov = m_active && (k >= END-P+1);
    check("busy", busy, m_active);
    check("in_ready", in_ready, exp_rdy);
    check("ch_bus", ch_now, exp_ch);
    check("out_valid", out_valid, exp_ov);
    check("done", done, m_active && k == END);
    check("out_data", {out_deg_r, out_l, out_u}, exp_ov ? {cr_deg_r, cr_l, cr_u} : '0);
    check("err", err, m_err);
    if (reset) begin
      if (abort) begin
        m_active = 1'b0;
        m_flush  = cnt;
      end else if (!m_active) begin
        if (in_valid) begin
          m_active = 1'b1;
          m_t0     = cnt;
          beats[0] = in_now;
          m_err    = 1'b0;
        end
      end else if (k <= P-1) begin
        if (in_valid) beats[k] = in_now;
        else begin
          m_err    = 1'b1;
          m_active = 1'b0;
          m_flush  = cnt;
        end
      end else if (k == END) begin
        m_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ident) {cr_deg_r, cr_deg_q, cr_stop, cr_start, cr_r, cr_q, cr_l, cr_u} = chist[(cnt - CL) % HN];
    else       {cr_deg_r, cr_deg_q, cr_stop, cr_start, cr_r, cr_q, cr_l, cr_u} = {$urandom(), $urandom()};
  endtask

  task automatic rnd_inputs();
    {in_deg_r, in_deg_q, in_stop, in_start, in_r, in_q, in_l, in_u} = {$urandom(), $urandom()};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); rnd_inputs();
      in_valid = 1'b0;
      abort    = 1'b0;
    end
  endtask

  task automatic problem(input int gap_at, input int abort_at);
    for (int j = 0; j <= END+1; j++) begin
      tick(); rnd_inputs();
      in_valid = (j < P) ? (gap_at < 0 || j < gap_at) : ($urandom_range(0, 3) == 0);
      abort    = (j == abort_at);
    end
  endtask

  initial begin
    rst_rec = '0;
    rst_rec[STOPB]   = 1'b1;
    rst_rec[STOPB-1] = 1'b1;
    for (int i = 0; i < HN; i++) chist[i] = rst_rec;
    {cr_deg_r, cr_deg_q, cr_stop, cr_start, cr_r, cr_q, cr_l, cr_u} = rst_rec;

    idle(3);
    tick(); reset = 1'b1;
    idle(4);

    // Identity chain, in_l = 1..12, only beat 0 carries stop=0
    ident = 1'b1;
    tick(); rnd_inputs(); in_valid = 1'b1; in_l = W'(1); in_stop = 1'b0;
    for (int j = 1; j < P; j++) begin
      tick(); rnd_inputs(); in_valid = 1'b1; in_l = W'(j + 1); in_stop = 1'b1;
      if (j == 1) begin #1; check("lit_pass0_ch_l", ch_l, 1); end
    end
    for (int k = P; k <= END+1; k++) begin
      tick(); rnd_inputs(); in_valid = (k >= 40);
      #1;
      case (k)
        13: check("lit_stop_before_lag", ch_stop, 1);
        16: check("lit_stop_lagged", ch_stop, 0);
        40: check("lit_out_not_yet", out_valid, 0);
        41: begin check("lit_out_first_v", out_valid, 1); check("lit_out_first_l", out_l, 1); end
        52: begin check("lit_done", done, 1); check("lit_out_last_l", out_l, 12); check("lit_hold_rdy0", in_ready, 0); end
        53: begin check("lit_busy_low", busy, 0); check("lit_hold_rdy1", in_ready, 1); end
        default: ;
      endcase
    end
    // Problem accepted back-to-back at t0+53; finish loading and let it run
    for (int j = 1; j < P; j++) begin tick(); rnd_inputs(); in_valid = 1'b1; end
    idle(END - P + 2);

    // Load gap at beat 6
    ident = 1'b0;
    idle(3);
    tick(); rnd_inputs(); in_valid = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick(); rnd_inputs(); in_valid = (j < 6);
      if (j == 7) begin
        #1;
        check("lit_gap_err", err, 1);
        check("lit_gap_busy", busy, 0);
        check("lit_gap_stop", ch_stop, 1);
      end
    end
    idle(15);

    // Abort at t0+20, then a clean problem
    tick(); rnd_inputs(); in_valid = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      tick(); rnd_inputs(); in_valid = (j < P); abort = (j == 20);
      if (j == 1)  begin #1; check("lit_err_cleared", err, 0); end
      if (j == 21) begin #1; check("lit_abort_busy", busy, 0); check("lit_abort_ov", out_valid, 0); end
    end
    idle(2);
    ident = 1'b1;
    problem(-1, -1);
    idle(2);

    // Reset at t0+30
    tick(); rnd_inputs(); in_valid = 1'b1; abort = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      tick(); rnd_inputs(); in_valid = (j < P);
      if (j == 30) begin
        reset = 1'b0;
        #1;
        check("lit_rst_busy", busy, 0);
        check("lit_rst_ov", out_valid, 0);
        check("lit_rst_done", done, 0);
        check("lit_rst_stop", ch_stop, 1);
        check("lit_rst_start", ch_start, 1);
        check("lit_rst_err", err, 0);
      end
    end
    idle(2);
    tick(); reset = 1'b1; in_valid = 1'b0;
    #1; check("lit_rel_rdy", in_ready, 1);
    idle(3);

    // Randomized problems
    repeat (25) begin
      int g, a;
      ident = ($urandom_range(0, 1) == 1);
      g = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, P-1)) : -1;
      a = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, END)) : -1;
      problem(g, a);
      idle($urandom_range(0, 3));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/euclid_fold_ctrl.md
EUCLID_FOLD_CTRL -- requirements
Module: euclid_fold_ctrl

Interface
REQ-001 SHALL have parameter W, default 13, polynomial coefficient width in bits.
REQ-002 SHALL have parameter DW, default 5, degree field width.
REQ-003 SHALL have parameter CHAIN_LAT, default 4, latency in cycles of the external euclidean cell chain, one cycle per cell.
REQ-004 SHALL have parameter LOOP_DLY, default 8, depth of the recirculation delay line; loop period P = CHAIN_LAT + LOOP_DLY.
REQ-005 SHALL have parameter NPASS, default 4, number of passes through the chain per problem; NPASS >= 2.
REQ-006 SHALL have parameter STOP_EXTRA, default 3, extra delay on the recirculated stop flag.
REQ-007 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous flush.
- in_valid  in  1  input beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_deg_r, in_deg_q  in  DW each  initial degrees.
- in_stop, in_start  in  1 each  per-beat flags.
- in_r, in_q, in_l, in_u  in  W each  coefficients.
- ch_deg_r, ch_deg_q, ch_stop, ch_start, ch_r, ch_q, ch_l, ch_u  out  (DW, DW, 1, 1, W, W, W, W)  drive to cell chain.
- cr_deg_r, cr_deg_q, cr_stop, cr_start, cr_r, cr_q, cr_l, cr_u  in  same widths  return from cell chain.
- out_valid  out  1  result beat valid.
- out_l, out_u  out  W each  result coefficients (cr_l, cr_u during output window).
- out_deg_r  out  DW  result degree (cr_deg_r during output window).
- done  out  1  one-cycle pulse on last output beat.
- busy  out  1  high whenever state != IDLE.
- err  out  1  sticky load-gap flag.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, RUN, OUT.
REQ-011 IDLE: in_ready=1; accepted beat -> LOAD, beat counter cyc=1.
REQ-012 LOAD: in_ready=1; SHALL accept exactly P consecutive beats in total, then -> RUN with in_ready=0.
REQ-013 If in_valid=0 in any LOAD cycle, SHALL set err=1 and return to IDLE, flushing as on abort.
REQ-014 All in_* SHALL be registered once; ch_* carries the registered input one cycle after acceptance (pass 0).
REQ-015 Passes >=1: ch_* SHALL equal cr_* delayed LOOP_DLY cycles; ch_stop SHALL equal cr_stop delayed LOOP_DLY+STOP_EXTRA.
REQ-016 Mux select SHALL switch from input register to recirculation exactly P cycles after the first pass-0 beat appears on ch_*.
REQ-017 Counters: cyc 0..P-1 wraps; pass 0..NPASS-1 increments on cyc wrap; no other terminal condition.
REQ-018 OUT window: out_valid=1 for exactly P cycles, starting CHAIN_LAT cycles after the first pass-(NPASS-1) beat appears on ch_*; done=1 on the P-th beat; -> IDLE next cycle.
REQ-019 Outside the OUT window, out_valid=0 and out_l/out_u/out_deg_r SHALL hold 0.
REQ-020 Input beats presented while not in IDLE/LOAD SHALL be ignored (in_ready=0).
REQ-021 abort=1 SHALL take effect the next cycle, overriding all other events:
- state -> IDLE.
- all delay lines -> reset values.
- out_valid=0; no done pulse.
REQ-022 err SHALL clear only on reset or on the next accepted IDLE beat.
REQ-023 Delay lines SHALL be plain shift registers, with no arithmetic on coefficient data.

Reset
REQ-030 On reset low, asynchronously:
- state=IDLE, counters=0, err=0, busy=0, out_valid=0, done=0.
- in_ready=1 after reset release.
- All data/degree registers=0.
- All stop and start registers, plus ch_stop/ch_start, =1.
REQ-031 Reset mid-operation SHALL discard the problem; no partial output.

Verification (defaults, P=12; t0 = first acceptance)
REQ-040 Cycle 0 beat accepted: ch_* shows it at t0+1; recirculation selected from t0+13; out_valid t0+41..t0+52; done at t0+52; busy low t0+53.
REQ-041 Identity chain (cr_* = ch_* delayed 4), in_l beats 1..12 -> out_l 1..12 in order; ch_stop lags the data path by 3 cycles on recirculation.
REQ-042 in_valid dropped at LOAD beat 6 -> err=1, IDLE next cycle; ch_stop=1, no out_valid.
REQ-043 abort at t0+20 -> IDLE at t0+21, busy=0; new problem then completes normally with correct timing.
REQ-044 reset asserted at t0+30 -> all outputs at reset values immediately; in_ready=1 after release.
REQ-045 Back-to-back problems: second in_valid held from t0+40 -> accepted only at t0+53.
